// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between execute stage and muldiv_seq
// master: execute stage (drives start/op/rs1/rs2/flush)
// slave:  muldiv_seq    (drives busy/done/result)
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply / divide sequencer
// clk    : rising-edge clock
// rst_n  : asynchronous active-low reset
// bus    : slave side of muldiv_seq_if
//          start/op/rs1/rs2 request, flush abort, busy/done/result status
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state;
  // op[2] is implied by which state we are in, so only the low bits are kept
  logic [1:0]      op_q;
  // a_q: multiplicand, or dividend that is shifted out while quotient bits shift in
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  // Remainder is always below the divisor, so it fits in XLEN bits between steps;
  // the extra bit exists only in the shifted compare value rem_sh.
  logic [XLEN-1:0] rem_q;
  logic [4:0]      cnt_q;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] result_q;

  // Accept decode, from the live request
  logic            accept;
  logic            in_signed;
  logic            in_s1;
  logic            in_s2;
  logic            in_special;
  logic [XLEN-1:0] in_special_res;

  assign accept    = bus.start && !bus.flush && (state == S_IDLE || state == S_DONE);
  assign in_signed = !bus.op[0];
  assign in_s1     = in_signed && bus.rs1[XLEN-1];
  assign in_s2     = in_signed && bus.rs2[XLEN-1];

  always_comb begin
    in_special     = 1'b0;
    in_special_res = '0;
    if (bus.rs2 == '0) begin
      in_special     = 1'b1;
      in_special_res = bus.op[1] ? bus.rs1 : '1;
    end else if (in_signed && bus.rs1 == INT_MIN && bus.rs2 == '1) begin
      in_special     = 1'b1;
      in_special_res = bus.op[1] ? '0 : INT_MIN;
    end
  end

  // Multiply: sign-extend each operand to 2*XLEN; the low 2*XLEN bits of the
  // product are exact for every signedness combination.
  logic              mul_sa;
  logic              mul_sb;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  assign mul_sa  = (op_q != 2'b11) && a_q[XLEN-1];
  assign mul_sb  = !op_q[1] && b_q[XLEN-1];
  assign mul_a   = {{XLEN{mul_sa}}, a_q};
  assign mul_b   = {{XLEN{mul_sb}}, b_q};
  assign product = mul_a * mul_b;
  assign mul_res = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Restoring divide step
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_sub;
  logic            q_bit;

  assign rem_sh  = {rem_q, a_q[XLEN-1]};
  assign q_bit   = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh - {1'b0, b_q};

  // Sign fix-up
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign quo_fix = q_neg ? -a_q : a_q;
  assign rem_fix = r_neg ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q <= bus.op[1:0];
            if (!bus.op[2]) begin
              a_q   <= bus.rs1;
              b_q   <= bus.rs2;
              state <= S_MUL;
            end else if (in_special) begin
              a_q      <= bus.rs1;
              b_q      <= bus.rs2;
              result_q <= in_special_res;
              state    <= S_DONE;
            end else begin
              a_q   <= in_s1 ? -bus.rs1 : bus.rs1;
              b_q   <= in_s2 ? -bus.rs2 : bus.rs2;
              rem_q <= '0;
              cnt_q <= 5'd31;
              q_neg <= in_s1 ^ in_s2;
              r_neg <= in_s1;
              state <= S_DIV;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MUL: begin
          result_q <= mul_res;
          state    <= S_DONE;
        end
        S_DIV: begin
          rem_q <= q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
          a_q   <= {a_q[XLEN-2:0], q_bit};
          if (cnt_q == 5'd0) begin
            state <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_FIX: begin
          result_q <= op_q[1] ? rem_fix : quo_fix;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: plain 64-bit / int arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0]        p;
    int                 si, sj;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = a;
    sj = b;
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(si / sj);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(si % sj);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present a request for one edge, then scramble the operand pins
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.rs1   = $urandom;
    bus.rs2   = $urandom;
  endtask

  // Returns at the negedge of the done cycle; lat = -1 if it never came
  task automatic wait_done(output int lat, output int nbusy, output logic [31:0] res);
    lat   = -1;
    nbusy = 0;
    res   = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nbusy, output logic [31:0] res);
    issue(op, a, b);
    wait_done(lat, nbusy, res);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as   [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [4] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int lat, nb;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, nb, res);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, want[i]); end
      checks++; if (lat != 2 || nb != 1) begin errors++; $display("FAIL mul_timing[%0d]: lat=%0d busy=%0d want 2 1", i, lat, nb); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] want [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat, nb;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, nb, res);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, res, want[i]); end
      checks++; if (lat != 34 || nb != 33) begin errors++; $display("FAIL div_timing[%0d]: lat=%0d busy=%0d want 34 33", i, lat, nb); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops  [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as   [4] = '{32'h1234_5678, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat, nb;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, nb, res);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, want[i]); end
      checks++; if (lat != 1 || nb != 0) begin errors++; $display("FAIL special_timing[%0d]: lat=%0d busy=%0d want 1 0", i, lat, nb); end
    end
  endtask

  task automatic test_random();
    int lat, nb;
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int bad_res = 0;
    int bad_lat = 0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, lat, nb, res);
      checks++;
      if (res !== ref_result(op, a, b)) begin
        errors++; bad_res++;
        $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, ref_result(op, a, b));
      end
      checks++;
      if (lat != ref_latency(op, a, b)) begin
        errors++; bad_lat++;
        $display("FAIL random_latency op=%0d a=%h b=%h: got %0d want %0d", op, a, b, lat, ref_latency(op, a, b));
      end
    end
  endtask

  task automatic test_flush();
    int lat, nb, ndone, nbusy;
    logic [31:0] res;
    run_op(3'd0, 32'd3, 32'd5, lat, nb, res);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL flush_setup: got %h want %h", res, 32'd15); end
    issue(3'd4, 32'd1000, 32'hFFFF_FFFD);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    checks++; if (ndone != 0 || nbusy != 0) begin errors++; $display("FAIL flush_abort: done=%0d busy=%0d want 0 0", ndone, nbusy); end
    checks++; if (bus.result !== 32'd15) begin errors++; $display("FAIL flush_result_held: got %h want %h", bus.result, 32'd15); end
    run_op(3'd5, 32'd100, 32'd7, lat, nb, res);
    checks++; if (res !== 32'd14 || lat != 34) begin errors++; $display("FAIL flush_recover: got %h lat=%0d want %h 34", res, lat, 32'd14); end
  endtask

  task automatic test_start_flush();
    int ndone, nbusy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd6;
    bus.rs2   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    checks++; if (ndone != 0 || nbusy != 0) begin errors++; $display("FAIL start_with_flush: done=%0d busy=%0d want 0 0", ndone, nbusy); end
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL start_with_flush_result: got %h want %h", bus.result, 32'd14); end
  endtask

  task automatic test_start_busy();
    int lat, nb;
    logic [31:0] res;
    issue(3'd5, 32'd100, 32'd7);
    lat = -1;
    nb  = 0;
    res = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.rs1   = 32'd6;
        bus.rs2   = 32'd7;
      end
      if (k == 8) bus.start = 1'b0;
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        break;
      end
    end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL start_busy_result: got %h want %h", res, 32'd14); end
    checks++; if (lat != 34 || nb != 33) begin errors++; $display("FAIL start_busy_timing: lat=%0d busy=%0d want 34 33", lat, nb); end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic [31:0] res;
    issue(3'd5, 32'd1000, 32'd10);
    wait_done(lat, nb, res);
    checks++; if (res !== 32'd100 || lat != 34) begin errors++; $display("FAIL b2b_first: got %h lat=%0d want %h 34", res, lat, 32'd100); end
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd12345;
    bus.rs2   = 32'd678;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat, nb, res);
    checks++; if (res !== 32'd8369910 || lat != 2) begin errors++; $display("FAIL b2b_second: got %h lat=%0d want %h 2", res, lat, 32'd8369910); end
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    logic [31:0] res;
    issue(3'd4, 32'hFFFF_FF9C, 32'd7);
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++; $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, lat, nb, res);
    checks++; if (res !== 32'd1 || lat != 2) begin errors++; $display("FAIL reset_mid_recover: got %h lat=%0d want 1 2", res, lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_start_flush();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
